// File: rtl/perf_counter_pkg.sv
// Shared definitions for the performance counter bank.
package perf_counter_pkg;

  // Run-state encoding of the bank FSM
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } run_state_e;

  // Overflow handling modes
  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Channel-select width; a single channel still gets a 1-bit select
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter_channel.sv
// One live counter with sticky overflow flag and wrap/saturate handling.
module perf_counter_channel
  import perf_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  logic at_max;

  assign at_max = (count == '1);

  // Count update: reset and clear win over increment; overflow is sticky
  always_ff @(posedge CLK) begin
    if (Reset || clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (inc) begin
      if (at_max) begin
        overflow <= 1'b1;
        if (SATURATE == MODE_WRAP) begin
          count <= '0;
        end
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NCH performance counters: run FSM, per-channel counters,
// snapshot shadow registers and a registered read mux.
module perf_counter_bank
  import perf_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NCH      = 4,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       Stop,
  input  logic                       Clear,
  input  logic                       Snap,
  input  logic [NCH-1:0]             Event,
  input  logic [sel_width(NCH)-1:0]  RdSel,
  output logic [WIDTH-1:0]           RdData,
  output logic [NCH-1:0]             Overflow,
  output logic                       SnapValid,
  output logic                       Running
);

  localparam int unsigned SELW = sel_width(NCH);

  run_state_e       state;
  logic [NCH-1:0]   inc;
  logic [WIDTH-1:0] live   [NCH];
  logic [WIDTH-1:0] shadow [NCH];
  logic [WIDTH-1:0] rd_next;

  assign Running = (state == RUN);

  // Channel 0 is the cycle counter: its event bit is forced high
  assign inc = (Event | NCH'(1)) & {NCH{Running}};

  // Run FSM; simultaneous Start and Stop leave the state unchanged
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, HALT: if (Start && !Stop) state <= RUN;
        RUN:        if (Stop && !Start) state <= HALT;
        default:    state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    perf_counter_channel #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_ch (
      .CLK      (CLK),
      .Reset    (Reset),
      .inc      (inc[k]),
      .clear    (Clear),
      .count    (live[k]),
      .overflow (Overflow[k])
    );
  end

  // Snapshot capture of pre-edge live values, plus the valid pulse
  always_ff @(posedge CLK) begin
    if (Reset) begin
      SnapValid <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      SnapValid <= Snap;
      if (Snap) begin
        for (int unsigned i = 0; i < NCH; i++) begin
          shadow[i] <= live[i];
        end
      end
    end
  end

  // Read mux; selects beyond the last channel yield zero
  always_comb begin
    rd_next = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (RdSel == SELW'(i)) begin
        rd_next = shadow[i];
      end
    end
  end

  // Registered read data
  always_ff @(posedge CLK) begin
    if (Reset) begin
      RdData <= '0;
    end else begin
      RdData <= rd_next;
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a default instance and two
// narrow 3-channel instances (wrap and saturate) driven in lockstep.
module tb_perf_counter_bank;

  logic       CLK = 1'b0;
  logic       Reset, Start, Stop, Clear, Snap;
  logic [3:0] Event;
  logic [1:0] RdSel;

  logic [15:0] rd_m;
  logic [3:0]  ovf_m;
  logic        sv_m, run_m;
  logic [3:0]  rd_w, rd_s;
  logic [2:0]  ovf_w, ovf_s;
  logic        sv_w, sv_s, run_w, run_s;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  perf_counter_bank #(.WIDTH(16), .NCH(4), .SATURATE(0)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Stop(Stop), .Clear(Clear),
    .Snap(Snap), .Event(Event), .RdSel(RdSel), .RdData(rd_m),
    .Overflow(ovf_m), .SnapValid(sv_m), .Running(run_m)
  );

  perf_counter_bank #(.WIDTH(4), .NCH(3), .SATURATE(0)) dut_w (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Stop(Stop), .Clear(Clear),
    .Snap(Snap), .Event(Event[2:0]), .RdSel(RdSel), .RdData(rd_w),
    .Overflow(ovf_w), .SnapValid(sv_w), .Running(run_w)
  );

  perf_counter_bank #(.WIDTH(4), .NCH(3), .SATURATE(1)) dut_s (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Stop(Stop), .Clear(Clear),
    .Snap(Snap), .Event(Event[2:0]), .RdSel(RdSel), .RdData(rd_s),
    .Overflow(ovf_s), .SnapValid(sv_s), .Running(run_s)
  );

  typedef struct packed {
    logic        st;
    logic        sp;
    logic        sn;
    logic [1:0]  sel;
    logic        run;
    logic        sv;
    logic [15:0] rd;
  } vec_t;

  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] em;
    logic [3:0]  ew;
    logic [3:0]  es;
  } rd_t;

  vec_t tab [18];
  rd_t  rtab [4];

  function automatic vec_t mk(input logic st, sp, sn, input logic [1:0] sel,
                              input logic run, sv, input logic [15:0] rd);
    vec_t v;
    v.st = st; v.sp = sp; v.sn = sn; v.sel = sel;
    v.run = run; v.sv = sv; v.rd = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic st, sp, cl, sn, input logic [3:0] ev, input logic [1:0] sel);
    Start = st; Stop = sp; Clear = cl; Snap = sn; Event = ev; RdSel = sel;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cyc(0, 0, 0, 0, 4'h0, 2'd0);
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    // Reset must override every command issued alongside it
    cyc(1, 0, 1, 1, 4'hF, 2'd0);
    cyc(1, 0, 1, 1, 4'hF, 2'd0);
    Reset = 1'b0;
    check("reset_running", run_m, 0);
    check("reset_snapvalid", sv_m, 0);
    check("reset_rddata", rd_m, 0);
    check("reset_overflow", ovf_m, 0);

    // Start, 10 counting cycles, snapshot of the cycle channel
    cyc(1, 0, 0, 0, 4'h0, 2'd0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 4'h0, 2'd0);
    cyc(0, 0, 0, 1, 4'h0, 2'd0);
    check("snap10_valid", sv_m, 1);
    cyc(0, 0, 0, 0, 4'h0, 2'd0);
    check("snap10_rddata", rd_m, 10);
    check("snap10_valid_drop", sv_m, 0);

    // Advance to ch0 = 20, then reset mid-run together with Snap
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 4'h0, 2'd0);
    check("prereset_running", run_m, 1);
    check("prereset_ovf_w", ovf_w, 3'b001);
    check("prereset_ovf_s", ovf_s, 3'b001);
    Reset = 1'b1;
    cyc(0, 0, 0, 1, 4'h0, 2'd0);
    Reset = 1'b0;
    check("midreset_running", run_m, 0);
    check("midreset_rddata", rd_m, 0);
    check("midreset_snapvalid", sv_m, 0);
    check("midreset_ovf_w", ovf_w, 0);
    check("midreset_ovf_s", ovf_s, 0);
    cyc(0, 0, 0, 0, 4'h0, 2'd0);
    check("midreset_shadow0", rd_m, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 4'h0, 2'd0);
    check("idle_running", run_m, 0);
    cyc(0, 0, 0, 1, 4'h0, 2'd0);
    cyc(0, 0, 0, 0, 4'h0, 2'd0);
    check("idle_ch0_zero", rd_m, 0);

    // Run/stop/restart sequence: Stop cycle counts, Start cycle does not
    do_reset();
    tab[0]  = mk(1, 0, 0, 2'd0, 1, 0, 0);
    tab[1]  = mk(0, 0, 0, 2'd0, 1, 0, 0);
    tab[2]  = mk(0, 0, 0, 2'd0, 1, 0, 0);
    tab[3]  = mk(1, 1, 0, 2'd0, 1, 0, 0);
    tab[4]  = mk(0, 0, 0, 2'd0, 1, 0, 0);
    tab[5]  = mk(0, 0, 0, 2'd0, 1, 0, 0);
    tab[6]  = mk(0, 1, 0, 2'd0, 0, 0, 0);
    tab[7]  = mk(0, 0, 0, 2'd0, 0, 0, 0);
    tab[8]  = mk(0, 0, 0, 2'd0, 0, 0, 0);
    tab[9]  = mk(1, 1, 0, 2'd0, 0, 0, 0);
    tab[10] = mk(0, 0, 0, 2'd0, 0, 0, 0);
    tab[11] = mk(0, 0, 0, 2'd0, 0, 0, 0);
    tab[12] = mk(1, 0, 0, 2'd0, 1, 0, 0);
    tab[13] = mk(0, 0, 0, 2'd0, 1, 0, 0);
    tab[14] = mk(0, 0, 0, 2'd0, 1, 0, 0);
    tab[15] = mk(0, 0, 0, 2'd0, 1, 0, 0);
    tab[16] = mk(0, 0, 1, 2'd0, 1, 1, 0);
    tab[17] = mk(0, 0, 0, 2'd0, 1, 0, 9);
    for (int i = 0; i < 18; i++) begin
      cyc(tab[i].st, tab[i].sp, 1'b0, tab[i].sn, 4'h0, tab[i].sel);
      check($sformatf("runseq%0d_running", i), run_m, tab[i].run);
      check($sformatf("runseq%0d_snapvalid", i), sv_m, tab[i].sv);
      check($sformatf("runseq%0d_rddata", i), rd_m, tab[i].rd);
    end

    // 17 Event[1] pulses: wrap vs saturate on 4-bit counters
    do_reset();
    cyc(1, 0, 0, 0, 4'h0, 2'd0);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 4'h2, 2'd0);
    check("ev15_ovf_w", ovf_w, 3'b000);
    check("ev15_ovf_s", ovf_s, 3'b000);
    cyc(0, 0, 0, 0, 4'h2, 2'd0);
    check("ev16_ovf_w", ovf_w, 3'b011);
    check("ev16_ovf_s", ovf_s, 3'b011);
    cyc(0, 0, 0, 0, 4'h2, 2'd0);
    cyc(0, 1, 0, 0, 4'h0, 2'd0);
    cyc(0, 0, 0, 1, 4'h0, 2'd1);
    check("ev17_ovf_m", ovf_m, 4'b0000);
    rtab[0] = '{sel: 2'd1, em: 16'd17, ew: 4'd1,  es: 4'd15};
    rtab[1] = '{sel: 2'd3, em: 16'd0,  ew: 4'd0,  es: 4'd0};
    rtab[2] = '{sel: 2'd0, em: 16'd18, ew: 4'd2,  es: 4'd15};
    rtab[3] = '{sel: 2'd2, em: 16'd0,  ew: 4'd0,  es: 4'd0};
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 4'h0, rtab[i].sel);
      check($sformatf("read_sel%0d_m", rtab[i].sel), rd_m, rtab[i].em);
      check($sformatf("read_sel%0d_w", rtab[i].sel), rd_w, rtab[i].ew);
      check($sformatf("read_sel%0d_s", rtab[i].sel), rd_s, rtab[i].es);
    end

    // Snap + Clear + Event[2] in one cycle, then back-to-back Snap
    do_reset();
    cyc(1, 0, 0, 0, 4'h0, 2'd0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 4'h4, 2'd2);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 4'h0, 2'd2);
    check("preclear_ovf_w", ovf_w, 3'b001);
    cyc(0, 0, 1, 1, 4'h4, 2'd2);
    check("clear_ovf_w", ovf_w, 0);
    check("clear_ovf_s", ovf_s, 0);
    check("clear_snapvalid", sv_m, 1);
    cyc(0, 0, 0, 1, 4'h0, 2'd2);
    check("b2b_snapvalid", sv_m, 1);
    check("preclear_shadow2_m", rd_m, 7);
    check("preclear_shadow2_w", rd_w, 7);
    check("preclear_shadow2_s", rd_s, 7);
    cyc(0, 0, 0, 0, 4'h0, 2'd2);
    check("b2b_snapvalid_drop", sv_m, 0);
    check("cleared_ch2", rd_m, 0);
    cyc(0, 0, 0, 0, 4'h0, 2'd0);
    check("cleared_ch0", rd_m, 0);
    check("still_running", run_m, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter WIDTH, default 16, counter and read-data bit width (2..64).
REQ-002 Parameter NCH, default 4, number of counter channels (1..16); channel 0 is the cycle channel.
REQ-003 Parameter SATURATE, default 0, overflow mode: 0 = wrap, 1 = saturate at all-ones.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Start  input  1  single-cycle command: enter RUN.
REQ-007 Stop  input  1  single-cycle command: enter HALT.
REQ-008 Clear  input  1  zero all counters and overflow flags; run state unchanged.
REQ-009 Snap  input  1  copy all live counters into shadow registers.
REQ-010 Event  input  NCH  per-channel increment strobes; bit 0 ignored.
REQ-011 RdSel  input  max(1,clog2(NCH))  shadow channel select.
REQ-012 RdData  output  WIDTH  registered shadow value of selected channel.
REQ-013 Overflow  output  NCH  sticky per-channel overflow flags.
REQ-014 SnapValid  output  1  one-cycle pulse, cycle after a Snap is accepted.
REQ-015 Running  output  1  high while state is RUN.

Function
REQ-016 Run FSM states: IDLE, RUN, HALT; IDLE/HALT -> RUN on Start; RUN -> HALT on Stop; Start and Stop together: no transition.
REQ-017 In RUN, channel 0 increments by 1 every cycle; channel k>0 increments by 1 on cycles with Event[k]=1; no counting in IDLE or HALT.
REQ-018 Counting begins the cycle after Start is sampled; the Stop cycle itself still counts.
REQ-019 Wrap mode: all-ones + 1 -> 0, Overflow[k] set same edge.
REQ-020 Saturate mode: count holds at all-ones; Overflow[k] set on any increment attempt at all-ones.
REQ-021 Overflow[k] stays set until Clear or Reset.
REQ-022 Priority per edge: Reset > Clear > increment; Clear + increment in same cycle -> count 0.
REQ-023 Snap captures pre-edge live values (before that cycle's increment or Clear); Snap + Clear same cycle -> shadow holds pre-clear values, live counters 0.
REQ-024 SnapValid asserts exactly one cycle after each Snap; back-to-back Snaps give back-to-back pulses.
REQ-025 RdData = shadow[RdSel] with one-cycle latency; RdSel >= NCH returns 0.
REQ-026 Shadow registers change only on Snap or Reset.

Reset
REQ-027 Reset forces state IDLE; all live counters, shadows, Overflow, RdData, SnapValid, Running to 0.
REQ-028 Reset mid-RUN: no increment on the reset edge; counting resumes only after a new Start.
REQ-029 Reset overrides Start, Stop, Clear, Snap in the same cycle.

Structure
REQ-030 Shared package perf_counter_pkg holds run-state enum (IDLE, RUN, HALT) and mode constants MODE_WRAP=0, MODE_SAT=1.
REQ-031 One sub-module perf_counter_channel: WIDTH/SATURATE parameters, inc/clear inputs, count/overflow outputs; instantiated NCH times.
REQ-032 FSM, snapshot bank and read mux live in the top level.

Verification
REQ-033 Reset, Start, 10 idle cycles, Snap, RdSel=0 -> RdData=10, SnapValid one pulse.
REQ-034 WIDTH=4, SATURATE=0, Start, 17 Event[1] pulses -> ch1=1, Overflow[1]=1; WIDTH=4, SATURATE=1 same stimulus -> ch1=15, Overflow[1]=1.
REQ-035 RUN 5 cycles, Stop, 5 cycles, Start, 3 cycles -> ch0 = 9 after snapshot (Stop cycle counts, Start cycle does not).
REQ-036 Ch2 at 7, Snap+Clear+Event[2] same cycle -> shadow ch2=7, live ch2=0, Overflow cleared.
REQ-037 Reset asserted mid-RUN with ch0=20 -> all outputs 0, state IDLE, ch0 stays 0 until Start.
REQ-038 NCH=3, RdSel=3 -> RdData=0 next cycle.
